// File: rtl/transi_pkg.sv
// Shared definitions for the TRANSI pattern path (shifter and downstream mux stage).
// Holds the FSM state encoding and the default width/period constants both stages agree on.
package transi_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHold = 2'd2,
        StDone = 2'd3
    } transi_state_e;

    // Defaults for the 50 MHz board build: one shift step per millisecond.
    localparam int unsigned TransiDataWidthDef   = 8;
    localparam int unsigned TransiTickPeriodDef  = 50000;
    localparam int unsigned TransiTickWidthDef   = 16;
    localparam int unsigned TransiRoundsWidthDef = 4;

endpackage

// File: rtl/transi_prescaler.sv
// Prescaler for the TRANSI shifter: counts enabled cycles 0..TICKPERIOD-1 and wraps.
// Ports:
//   clk_i   - system clock, rising edge
//   rst_i   - asynchronous reset, active-high
//   en_i    - count enable; the count holds its value while low
//   clr_i   - synchronous clear to 0 (wins over en_i)
//   tick_o  - high while enabled and the count sits at its terminal value
module transi_prescaler #(
    parameter int unsigned TRANSI_TICKPERIOD = 50000,
    parameter int unsigned TRANSI_TICKWIDTH  = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [TRANSI_TICKWIDTH-1:0] LastCount =
        TRANSI_TICKWIDTH'(TRANSI_TICKPERIOD - 1);

    logic [TRANSI_TICKWIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = (count_q == LastCount) ? '0 : count_q + 1'b1;
        end
    end

    assign tick_o = en_i && (count_q == LastCount);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/transi_pattern_shifter.sv
// TRANSI pattern shifter: holds a pattern and rotates it left one place per prescaler tick for a
// programmable number of full rotations (0 = forever), feeding the TRANSI output mux.
// Ports:
//   CC_TRANSI_CLOCK_50       - system clock, rising edge
//   CC_TRANSI_RESET_InHigh   - asynchronous reset, active-high
//   CC_TRANSI_load_In        - strobe: capture CC_TRANSI_pattern_InBUS (IDLE only)
//   CC_TRANSI_pattern_InBUS  - pattern to load
//   CC_TRANSI_start_In       - strobe: begin rotating (IDLE only); samples rounds_InBUS
//   CC_TRANSI_pause_In       - level: freeze rotation while high
//   CC_TRANSI_rounds_InBUS   - full rotations to run, 0 = run forever
//   CC_TRANSI_TRANSI_OutBUS  - current pattern register
//   CC_TRANSI_select_OutBUS  - mux select, high while running or held
//   CC_TRANSI_busy_Out       - high while running or held
//   CC_TRANSI_done_Out       - one-cycle pulse when the requested rounds complete
module transi_pattern_shifter
    import transi_pkg::*;
#(
    parameter int unsigned TRANSI_DATAWIDTH   = TransiDataWidthDef,
    parameter int unsigned TRANSI_TICKPERIOD  = TransiTickPeriodDef,
    parameter int unsigned TRANSI_TICKWIDTH   = TransiTickWidthDef,
    parameter int unsigned TRANSI_ROUNDSWIDTH = TransiRoundsWidthDef
) (
    input  logic                          CC_TRANSI_CLOCK_50,
    input  logic                          CC_TRANSI_RESET_InHigh,
    input  logic                          CC_TRANSI_load_In,
    input  logic [TRANSI_DATAWIDTH-1:0]   CC_TRANSI_pattern_InBUS,
    input  logic                          CC_TRANSI_start_In,
    input  logic                          CC_TRANSI_pause_In,
    input  logic [TRANSI_ROUNDSWIDTH-1:0] CC_TRANSI_rounds_InBUS,
    output logic [TRANSI_DATAWIDTH-1:0]   CC_TRANSI_TRANSI_OutBUS,
    output logic                          CC_TRANSI_select_OutBUS,
    output logic                          CC_TRANSI_busy_Out,
    output logic                          CC_TRANSI_done_Out
);

    localparam int unsigned StepWidth = (TRANSI_DATAWIDTH > 2) ? $clog2(TRANSI_DATAWIDTH) : 1;
    localparam logic [StepWidth-1:0] LastStep = StepWidth'(TRANSI_DATAWIDTH - 1);

    transi_state_e                 state_q, state_d;
    logic [TRANSI_DATAWIDTH-1:0]   pattern_q, pattern_d;
    logic [StepWidth-1:0]          step_q, step_d;
    logic [TRANSI_ROUNDSWIDTH-1:0] round_q, round_d;
    logic [TRANSI_ROUNDSWIDTH-1:0] rounds_q, rounds_d;
    logic                          select_q, select_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;

    logic advance;
    logic pre_clr;
    logic tick;

    // HOLD is just "pause was high last cycle": with pause low the held cycle already counts,
    // so the step resumes exactly where the prescaler was frozen.
    assign advance = ((state_q == StRun) || (state_q == StHold)) && !CC_TRANSI_pause_In;
    assign pre_clr = (state_q == StIdle) && CC_TRANSI_start_In;

    transi_prescaler #(
        .TRANSI_TICKPERIOD (TRANSI_TICKPERIOD),
        .TRANSI_TICKWIDTH  (TRANSI_TICKWIDTH)
    ) u_prescaler (
        .clk_i  (CC_TRANSI_CLOCK_50),
        .rst_i  (CC_TRANSI_RESET_InHigh),
        .en_i   (advance),
        .clr_i  (pre_clr),
        .tick_o (tick)
    );

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        step_d    = step_q;
        round_d   = round_q;
        rounds_d  = rounds_q;

        case (state_q)
            StIdle: begin
                if (CC_TRANSI_load_In) begin
                    pattern_d = CC_TRANSI_pattern_InBUS;
                end
                if (CC_TRANSI_start_In) begin
                    state_d  = StRun;
                    rounds_d = CC_TRANSI_rounds_InBUS;
                    step_d   = '0;
                    round_d  = '0;
                end
            end
            StRun, StHold: begin
                if (CC_TRANSI_pause_In) begin
                    state_d = StHold;
                end else begin
                    state_d = StRun;
                    if (tick) begin
                        pattern_d = {pattern_q[TRANSI_DATAWIDTH-2:0],
                                     pattern_q[TRANSI_DATAWIDTH-1]};
                        if (step_q == LastStep) begin
                            step_d  = '0;
                            // Wraps silently in run-forever mode.
                            round_d = round_q + 1'b1;
                            if ((rounds_q != '0) && (round_d == rounds_q)) begin
                                state_d = StDone;
                            end
                        end else begin
                            step_d = step_q + 1'b1;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered copies decoded from the next state.
        select_d = (state_d == StRun) || (state_d == StHold);
        busy_d   = select_d;
        done_d   = (state_d == StDone);
    end

    always_ff @(posedge CC_TRANSI_CLOCK_50 or posedge CC_TRANSI_RESET_InHigh) begin
        if (CC_TRANSI_RESET_InHigh) begin
            state_q   <= StIdle;
            pattern_q <= '0;
            step_q    <= '0;
            round_q   <= '0;
            rounds_q  <= '0;
            select_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            step_q    <= step_d;
            round_q   <= round_d;
            rounds_q  <= rounds_d;
            select_q  <= select_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign CC_TRANSI_TRANSI_OutBUS = pattern_q;
    assign CC_TRANSI_select_OutBUS = select_q;
    assign CC_TRANSI_busy_Out      = busy_q;
    assign CC_TRANSI_done_Out      = done_q;

endmodule

// File: tb/tb_transi_pattern_shifter.sv
// Bench for transi_pattern_shifter with TICKPERIOD=4, DATAWIDTH=8.
module tb_transi_pattern_shifter;

    localparam int unsigned DW = 8;
    localparam int unsigned P  = 4;
    localparam int unsigned RW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [DW-1:0] pat = '0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic [RW-1:0] rounds = '0;
    logic [DW-1:0] out_bus;
    logic          sel;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    transi_pattern_shifter #(
        .TRANSI_DATAWIDTH   (DW),
        .TRANSI_TICKPERIOD  (P),
        .TRANSI_TICKWIDTH   (16),
        .TRANSI_ROUNDSWIDTH (RW)
    ) dut (
        .CC_TRANSI_CLOCK_50      (clk),
        .CC_TRANSI_RESET_InHigh  (rst),
        .CC_TRANSI_load_In       (load),
        .CC_TRANSI_pattern_InBUS (pat),
        .CC_TRANSI_start_In      (start),
        .CC_TRANSI_pause_In      (pause),
        .CC_TRANSI_rounds_InBUS  (rounds),
        .CC_TRANSI_TRANSI_OutBUS (out_bus),
        .CC_TRANSI_select_OutBUS (sel),
        .CC_TRANSI_busy_Out      (busy),
        .CC_TRANSI_done_Out      (done)
    );

    always #5 clk = ~clk;

    // Behavioural model: the output is the base pattern rotated by the number of shifts so far;
    // a shift happens every P un-paused active cycles.
    logic [DW-1:0] m_base = '0;
    int            m_shifts = 0;
    int            m_progress = 0;
    int            m_rounds = 0;
    bit            m_busy = 1'b0;
    bit            m_done = 1'b0;

    function automatic logic [DW-1:0] rotl(input logic [DW-1:0] v, input int n);
        int k;
        k = n % DW;
        return (k == 0) ? v : ((v << k) | (v >> (DW - k)));
    endfunction

    task automatic model_reset();
        m_base = '0; m_shifts = 0; m_progress = 0; m_rounds = 0;
        m_busy = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_step();
        if (m_busy) begin
            if (!pause) begin
                m_progress++;
                if (m_progress % P == 0) begin
                    m_shifts++;
                    if (m_rounds != 0 && m_shifts == m_rounds * DW) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else begin
            m_base = rotl(m_base, m_shifts);
            m_shifts = 0;
            if (load) m_base = pat;
            if (start) begin
                m_busy = 1'b1;
                m_rounds = int'(rounds);
                m_progress = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            chk("model_out", out_bus, rotl(m_base, m_shifts));
            chk("model_select", {7'd0, sel}, {7'd0, m_busy});
            chk("model_busy", {7'd0, busy}, {7'd0, m_busy});
            chk("model_done", {7'd0, done}, {7'd0, m_done});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input string name, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick(1);
            if (done) seen = 1'b1;
        end
        chk(name, {7'd0, seen}, 8'd1);
        tick(1);
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_out_now", out_bus, 8'h00);
        chk("rst_select_now", {7'd0, sel}, 8'd0);
        chk("rst_busy_now", {7'd0, busy}, 8'd0);
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        tick(1);
    endtask

    initial begin
        // Reset state
        tick(2);
        chk("reset_out", out_bus, 8'h00);
        chk("reset_select", {7'd0, sel}, 8'd0);
        chk("reset_done", {7'd0, done}, 8'd0);
        rst = 1'b0;
        tick(1);

        // Single rotation of 0x81
        load = 1'b1; pat = 8'h81;
        tick(1);
        load = 1'b0; start = 1'b1; rounds = 4'd1;
        tick(1);
        start = 1'b0;
        chk("t1_select", {7'd0, sel}, 8'd1);
        chk("t1_out0", out_bus, 8'h81);
        tick(3);
        chk("t1_out_pre", out_bus, 8'h81);
        tick(1);
        chk("t1_shift1", out_bus, 8'h03);
        tick(4);
        chk("t1_shift2", out_bus, 8'h06);
        tick(23);
        chk("t1_shift7", out_bus, 8'hC0);
        chk("t1_nodone", {7'd0, done}, 8'd0);
        tick(1);
        chk("t1_back", out_bus, 8'h81);
        chk("t1_done", {7'd0, done}, 8'd1);
        chk("t1_sel_off", {7'd0, sel}, 8'd0);
        tick(1);
        chk("t1_done_once", {7'd0, done}, 8'd0);

        // Pause mid-step: prescaler count 2 when frozen, two cycles left after release
        load = 1'b1; pat = 8'h81; start = 1'b1; rounds = 4'd1;
        tick(1);
        load = 1'b0; start = 1'b0;
        tick(6);
        pause = 1'b1;
        tick(1);
        chk("t2_held", out_bus, 8'h03);
        tick(9);
        chk("t2_held_end", out_bus, 8'h03);
        chk("t2_held_sel", {7'd0, sel}, 8'd1);
        pause = 1'b0;
        tick(1);
        chk("t2_rel1", out_bus, 8'h03);
        tick(1);
        chk("t2_rel2", out_bus, 8'h06);
        wait_done("t2_done_seen", 60);

        // Run forever, ignored load/start while running
        load = 1'b1; pat = 8'h01; start = 1'b1; rounds = 4'd0;
        tick(1);
        load = 1'b0; start = 1'b0;
        tick(96);
        chk("t3_out96", out_bus, 8'h01);
        chk("t3_busy", {7'd0, busy}, 8'd1);
        load = 1'b1; pat = 8'hFF; start = 1'b1; rounds = 4'd1;
        tick(1);
        load = 1'b0; start = 1'b0;
        tick(3);
        chk("t4_ignored", out_bus, 8'h02);
        tick(1);

        // Reset mid-run, then start without load
        async_reset();
        start = 1'b1; rounds = 4'd1;
        tick(1);
        start = 1'b0;
        chk("t6_sel", {7'd0, sel}, 8'd1);
        tick(5);
        chk("t6_zero", out_bus, 8'h00);
        wait_done("t6_done_seen", 40);

        // Load and start together
        load = 1'b1; pat = 8'h0F; start = 1'b1; rounds = 4'd2;
        tick(1);
        load = 1'b0; start = 1'b0;
        chk("t5_loaded", out_bus, 8'h0F);
        tick(4);
        chk("t5_shift1", out_bus, 8'h1E);
        wait_done("t5_done_seen", 80);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            load   = ($urandom_range(7) == 0);
            pat    = DW'($urandom);
            start  = ($urandom_range(9) == 0);
            rounds = RW'($urandom_range(2));
            if ($urandom_range(7) == 0) pause = ~pause;
            if ($urandom_range(299) == 0) async_reset();
            else tick(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
